des_perm_pipe: RTL and testbench

//  Pipelined, handshaked DES bit-permutation engine: applies IP or FP (IP^-1) per transaction,

---
 rtl/des_perm_pipe_if.sv | 29 ++
 rtl/des_perm_pipe.sv | 145 ++++++++++++++
 tb/tb_des_perm_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_perm_pipe_if.sv
// Handshake bundle for the DES IP/FP permutation pipe.
// The upstream/downstream environment uses master; the engine uses slave.
interface des_perm_pipe_if #(
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [63:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [31:0]      out_left;
    logic [31:0]      out_right;
    logic             out_mode;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       occupancy;

    modport master (
        output in_valid, in_mode, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_left, out_right, out_mode, out_tag, occupancy
    );

    modport slave (
        input  in_valid, in_mode, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_left, out_right, out_mode, out_tag, occupancy
    );
endinterface

// File: rtl/des_perm_pipe.sv
// Pipelined DES initial/final permutation engine with valid/ready handshake and sideband tag.
// Stage 1 captures the permuted block; later stages are pure delay with bubble collapsing.
module des_perm_pipe #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input logic            clk,
    input logic            rst_n,
    des_perm_pipe_if.slave bus
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("des_perm_pipe: STAGES must be in 1..4");
    end

    // IP source bit (DES numbering) for output bit k; rows 0-3 start at 58,60,62,64,
    // rows 4-7 at 57,59,61,63, and each column steps back by 8.
    function automatic int unsigned ip_src(int unsigned k);
        int unsigned r;
        int unsigned c;
        r = (k - 1) / 8;
        c = (k - 1) % 8;
        if (r < 4) begin
            ip_src = 58 + 2 * r - 8 * c;
        end else begin
            ip_src = 57 + 2 * (r - 4) - 8 * c;
        end
    endfunction

    // FP is the inverse of IP: output bit k comes from the input bit that IP sends to k.
    function automatic int unsigned fp_src(int unsigned k);
        fp_src = 0;
        for (int unsigned j = 1; j <= 64; j++) begin
            if (ip_src(j) == k) begin
                fp_src = j;
            end
        end
    endfunction

    logic [63:0] ip_blk;
    logic [63:0] fp_blk;
    logic [63:0] perm_blk;

    for (genvar k = 1; k <= 64; k++) begin : g_perm
        localparam int unsigned IpSrc = ip_src(k);
        localparam int unsigned FpSrc = fp_src(k);
        assign ip_blk[64-k] = bus.in_data[64-IpSrc];
        assign fp_blk[64-k] = bus.in_data[64-FpSrc];
    end

    assign perm_blk = bus.in_mode ? fp_blk : ip_blk;

    // Holds in_ready low through reset and until the first edge after release.
    logic ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        logic             v_q;
        logic [63:0]      data_q;
        logic             mode_q;
        logic [TAG_W-1:0] tag_q;
        logic             load;
        logic             v_in;
        logic [63:0]      d_in;
        logic             m_in;
        logic [TAG_W-1:0] t_in;

        // A stage may take new contents when empty or when its own contents move on.
        if (s == STAGES - 1) begin : g_last
            assign load = !v_q || bus.out_ready;
        end else begin : g_mid
            assign load = !v_q || g_stg[s+1].load;
        end

        if (s == 0) begin : g_first
            assign v_in = bus.in_valid && ready_q;
            assign d_in = perm_blk;
            assign m_in = bus.in_mode;
            assign t_in = bus.in_tag;
        end else begin : g_delay
            assign v_in = g_stg[s-1].v_q;
            assign d_in = g_stg[s-1].data_q;
            assign m_in = g_stg[s-1].mode_q;
            assign t_in = g_stg[s-1].tag_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q    <= 1'b0;
                data_q <= '0;
                mode_q <= 1'b0;
                tag_q  <= '0;
            end else if (load) begin
                v_q <= v_in;
                if (v_in) begin
                    data_q <= d_in;
                    mode_q <= m_in;
                    tag_q  <= t_in;
                end
            end
        end
    end

    logic       in_xfer;
    logic       out_xfer;
    logic [2:0] occ_q;
    logic [2:0] occ_d;

    assign bus.in_ready = ready_q && g_stg[0].load;
    assign in_xfer      = bus.in_valid && bus.in_ready;
    assign out_xfer     = bus.out_valid && bus.out_ready;

    always_comb begin
        occ_d = occ_q;
        if (in_xfer && !out_xfer) begin
            occ_d = occ_q + 3'd1;
        end else if (out_xfer && !in_xfer) begin
            occ_d = occ_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= 3'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign bus.occupancy = occ_q;
    assign bus.out_valid = g_stg[STAGES-1].v_q;
    assign bus.out_data  = g_stg[STAGES-1].data_q;
    assign bus.out_mode  = g_stg[STAGES-1].mode_q;
    assign bus.out_tag   = g_stg[STAGES-1].tag_q;
    assign bus.out_left  = g_stg[STAGES-1].data_q[63:32];
    assign bus.out_right = g_stg[STAGES-1].data_q[31:0];

endmodule

// File: tb/tb_des_perm_pipe.sv
// Self-checking bench for des_perm_pipe: known vectors, round trip, backpressure,
// full-rate streaming and mid-stream reset against a table-based permutation model.
module tb_des_perm_pipe;

    localparam int unsigned STAGES = 4;
    localparam int unsigned TAG_W  = 4;

    typedef struct {
        logic        mode;
        logic [63:0] data;
        logic [3:0]  tag;
    } blk_t;

    typedef struct {
        logic        mode;
        logic [63:0] data;
        logic [63:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    des_perm_pipe_if #(.TAG_W(TAG_W)) bus ();

    des_perm_pipe #(
        .STAGES(STAGES),
        .TAG_W (TAG_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1);
    end

    // FIPS 46-3 tables, output DES bit k = input DES bit table[k-1].
    int ip_t[64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                     62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                     57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                     61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    int fp_t[64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                     38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                     36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                     34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    function automatic logic [63:0] ref_perm(input logic mode, input logic [63:0] d);
        logic [63:0] r;
        logic [5:0]  di;
        logic [5:0]  si;
        int          t;
        r = '0;
        for (int k = 1; k <= 64; k++) begin
            t  = mode ? fp_t[k-1] : ip_t[k-1];
            di = 6'(64 - k);
            si = 6'(64 - t);
            r[di] = d[si];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single block through an empty pipe with out_ready=1; lat counts edges from capture on.
    task automatic run_vec(input logic m, input logic [63:0] d, input logic [3:0] t,
                           output logic [63:0] od, output logic [31:0] ol,
                           output logic [31:0] orr, output logic om, output logic [3:0] ot,
                           output int lat);
        bus.in_valid  = 1'b1;
        bus.in_mode   = m;
        bus.in_data   = d;
        bus.in_tag    = t;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("vec_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            @(negedge clk);
        end
        od  = bus.out_data;
        ol  = bus.out_left;
        orr = bus.out_right;
        om  = bus.out_mode;
        ot  = bus.out_tag;
        @(posedge clk);
        #1;
    endtask

    // Streams src through the engine, checking every result against the model in order.
    task automatic run_stream(input blk_t src[$], input bit rnd_in, input bit rnd_out,
                              output blk_t got[$], output int first_out, output int last_out,
                              output int stall_cnt);
        blk_t        sb[$];
        blk_t        e;
        blk_t        o;
        int          idx;
        int          cyc;
        int          budget;
        bit          hold;
        bit          in_x;
        bit          out_x;
        logic [63:0] p_data;
        logic        p_mode;
        logic [3:0]  p_tag;
        got.delete();
        idx       = 0;
        cyc       = 0;
        hold      = 1'b0;
        p_data    = '0;
        p_mode    = 1'b0;
        p_tag     = '0;
        first_out = -1;
        last_out  = -1;
        stall_cnt = 0;
        budget    = src.size() * 10 + 50;
        bus.in_valid = 1'b0;
        while (got.size() < src.size()) begin
            if (cyc >= budget) begin
                check("stream_timeout", 64'(got.size()), 64'(src.size()));
                break;
            end
            if (!bus.in_valid && idx < src.size() && (!rnd_in || $urandom_range(1, 0) == 1)) begin
                bus.in_valid = 1'b1;
                bus.in_mode  = src[idx].mode;
                bus.in_data  = src[idx].data;
                bus.in_tag   = src[idx].tag;
            end
            bus.out_ready = rnd_out ? 1'($urandom_range(1, 0)) : 1'b1;
            @(negedge clk);
            check("occupancy", 64'(bus.occupancy), 64'(sb.size()));
            check("occ_bound", 64'(bus.occupancy <= 3'(STAGES)), 64'(1));
            if (hold) begin
                check("stall_valid", 64'(bus.out_valid), 64'(1));
                check("stall_data", bus.out_data, p_data);
                check("stall_mode", 64'(bus.out_mode), 64'(p_mode));
                check("stall_tag", 64'(bus.out_tag), 64'(p_tag));
            end
            if (bus.in_valid && !bus.in_ready) stall_cnt++;
            in_x  = bus.in_valid && bus.in_ready;
            out_x = bus.out_valid && bus.out_ready;
            if (out_x) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("out_data", bus.out_data, e.data);
                    check("out_halves", {bus.out_left, bus.out_right}, e.data);
                    check("out_mode", 64'(bus.out_mode), 64'(e.mode));
                    check("out_tag", 64'(bus.out_tag), 64'(e.tag));
                end
                o.mode = bus.out_mode;
                o.data = bus.out_data;
                o.tag  = bus.out_tag;
                got.push_back(o);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (in_x) begin
                e.mode = src[idx].mode;
                e.data = ref_perm(src[idx].mode, src[idx].data);
                e.tag  = src[idx].tag;
                sb.push_back(e);
                idx++;
            end
            hold   = bus.out_valid && !bus.out_ready;
            p_data = bus.out_data;
            p_mode = bus.out_mode;
            p_tag  = bus.out_tag;
            @(posedge clk);
            #1;
            cyc++;
            if (in_x) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        vec_t        vecs[7];
        blk_t        src[$];
        blk_t        mid[$];
        blk_t        got[$];
        blk_t        b;
        logic [63:0] od;
        logic [31:0] ol;
        logic [31:0] orr;
        logic        om;
        logic [3:0]  ot;
        int          lat;
        int          f_out;
        int          l_out;
        int          stalls;

        vecs[0] = '{1'b0, 64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA};
        vecs[1] = '{1'b1, 64'h0A4CD99543423234, 64'h85E813540F0AB405};
        vecs[2] = '{1'b1, 64'hCC00CCFFF0AAF0AA, 64'h0123456789ABCDEF};
        vecs[3] = '{1'b0, 64'h8000000000000000, 64'h0000000001000000};
        vecs[4] = '{1'b1, 64'h0000000000000001, 64'h0200000000000000};
        vecs[5] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        vecs[6] = '{1'b1, 64'h0000000000000000, 64'h0000000000000000};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_occupancy", 64'(bus.occupancy), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_out_data", bus.out_data, 64'(0));
        check("rst_out_mode", 64'(bus.out_mode), 64'(0));
        check("rst_out_tag", 64'(bus.out_tag), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

        // Known-answer vectors through an empty pipe.
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i].mode, vecs[i].data, 4'(i), od, ol, orr, om, ot, lat);
            check("vec_latency", 64'(lat), 64'(STAGES));
            check("vec_data", od, vecs[i].exp);
            check("vec_left", 64'(ol), 64'(vecs[i].exp[63:32]));
            check("vec_right", 64'(orr), 64'(vecs[i].exp[31:0]));
            check("vec_mode", 64'(om), 64'(vecs[i].mode));
            check("vec_tag", 64'(ot), 64'(i));
        end

        // Full throughput: 32 back-to-back blocks of mixed mode.
        src.delete();
        for (int i = 0; i < 32; i++) begin
            b.mode = 1'($urandom_range(1, 0));
            b.data = {$urandom, $urandom};
            b.tag  = 4'(i);
            src.push_back(b);
        end
        run_stream(src, 1'b0, 1'b0, got, f_out, l_out, stalls);
        check("tput_count", 64'(got.size()), 64'(32));
        check("tput_first", 64'(f_out), 64'(STAGES));
        check("tput_consecutive", 64'(l_out - f_out), 64'(31));
        check("tput_in_ready", 64'(stalls), 64'(0));

        // Round trip: IP then FP on the IP results recovers the original blocks.
        src.delete();
        for (int i = 0; i < 1000; i++) begin
            b.mode = 1'b0;
            b.data = {$urandom, $urandom};
            b.tag  = 4'($urandom_range(15, 0));
            src.push_back(b);
        end
        run_stream(src, 1'b1, 1'b1, mid, f_out, l_out, stalls);
        check("rt_ip_count", 64'(mid.size()), 64'(1000));
        foreach (mid[i]) mid[i].mode = 1'b1;
        run_stream(mid, 1'b1, 1'b1, got, f_out, l_out, stalls);
        check("rt_fp_count", 64'(got.size()), 64'(1000));
        for (int i = 0; i < 1000 && i < got.size(); i++) begin
            check("rt_data", got[i].data, src[i].data);
            check("rt_tag", 64'(got[i].tag), 64'(src[i].tag));
        end

        // Backpressure: 16 blocks tagged 0..15 with random out_ready and mixed modes.
        src.delete();
        for (int i = 0; i < 16; i++) begin
            b.mode = 1'($urandom_range(1, 0));
            b.data = {$urandom, $urandom};
            b.tag  = 4'(i);
            src.push_back(b);
        end
        run_stream(src, 1'b0, 1'b1, got, f_out, l_out, stalls);
        check("bp_count", 64'(got.size()), 64'(16));
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            check("bp_order", 64'(got[i].tag), 64'(i));
        end

        // Mid-stream reset with a full pipe.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 1'b1;
        bus.in_data   = 64'hDEADBEEF01234567;
        bus.in_tag    = 4'hA;
        repeat (STAGES + 1) @(posedge clk);
        #1;
        @(negedge clk);
        check("full_occupancy", 64'(bus.occupancy), 64'(STAGES));
        check("full_out_valid", 64'(bus.out_valid), 64'(1));
        check("full_in_ready", 64'(bus.in_ready), 64'(0));
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'(0));
        check("arst_occupancy", 64'(bus.occupancy), 64'(0));
        check("arst_in_ready", 64'(bus.in_ready), 64'(0));
        check("arst_out_data", bus.out_data, 64'(0));
        check("arst_out_tag", 64'(bus.out_tag), 64'(0));
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rerst_in_ready", 64'(bus.in_ready), 64'(1));
        run_vec(1'b0, 64'h0123456789ABCDEF, 4'h5, od, ol, orr, om, ot, lat);
        check("rerst_latency", 64'(lat), 64'(STAGES));
        check("rerst_data", od, 64'hCC00CCFFF0AAF0AA);
        check("rerst_tag", 64'(ot), 64'(5));
        @(negedge clk);
        check("rerst_no_stale", 64'(bus.out_valid), 64'(0));
        check("rerst_occupancy", 64'(bus.occupancy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
